// File: rtl/esp_at_pkg.sv
// Shared types and constants for the ESP8266 AT-command initiator:
// FSM states, command ROM, and response pattern characters.
package esp_at_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_FINISH    = 2'd3
  } state_t;

  localparam logic [7:0] CH_O  = 8'h4F;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_R  = 8'h52;

  // Patterns are stored first-character-in-MSB.
  localparam logic [31:0] OK_PAT  = {CH_O, CH_K, CH_CR, CH_LF};
  localparam logic [39:0] ERR_PAT = {CH_E, CH_R, CH_R, CH_O, CH_R};

  function automatic logic [3:0] cmd_len(input logic [1:0] sel);
    case (sel)
      2'd0:    return 4'd4;
      2'd1:    return 4'd8;
      default: return 4'd13;
    endcase
  endfunction

  // Byte idx of the selected command; idx must be below cmd_len(sel).
  function automatic logic [7:0] cmd_byte(input logic [1:0] sel, input logic [3:0] idx);
    logic [103:0] s;
    case (sel)
      2'd0:    s = {72'd0, "AT\r\n"};
      2'd1:    s = {40'd0, "AT+RST\r\n"};
      2'd2:    s = "AT+CWMODE=1\r\n";
      default: s = "AT+CIPMUX=1\r\n";
    endcase
    s = s >> {cmd_len(sel) - 4'd1 - idx, 3'b000};
    return s[7:0];
  endfunction

endpackage

// File: rtl/esp_at_resp_matcher.sv
// Tracks progress through "OK\r\n" and "ERROR" on the received byte stream
// and flags the byte that completes either pattern.
module esp_at_resp_matcher
  import esp_at_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clear,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_hit_ok,
  output logic       o_hit_err
);

  logic [1:0]  r_ok_idx;
  logic [2:0]  r_err_idx;
  logic [31:0] w_ok_sh;
  logic [39:0] w_err_sh;
  logic [7:0]  w_ok_exp;
  logic [7:0]  w_err_exp;

  assign w_ok_sh   = OK_PAT >> {2'd3 - r_ok_idx, 3'b000};
  assign w_ok_exp  = w_ok_sh[7:0];
  assign w_err_sh  = ERR_PAT >> {3'd4 - r_err_idx, 3'b000};
  assign w_err_exp = w_err_sh[7:0];

  assign o_hit_ok  = i_rx_valid && (r_ok_idx == 2'd3) && (i_rx_data == w_ok_exp);
  assign o_hit_err = i_rx_valid && (r_err_idx == 3'd4) && (i_rx_data == w_err_exp);

  // Neither pattern repeats a prefix internally, so restarting on the
  // first character is enough to catch overlapping attempts like "OOK".
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ok_idx  <= 2'd0;
      r_err_idx <= 3'd0;
    end else if (i_clear) begin
      r_ok_idx  <= 2'd0;
      r_err_idx <= 3'd0;
    end else if (i_rx_valid) begin
      if (o_hit_ok)                   r_ok_idx <= 2'd0;
      else if (i_rx_data == w_ok_exp) r_ok_idx <= r_ok_idx + 2'd1;
      else if (i_rx_data == CH_O)     r_ok_idx <= 2'd1;
      else                            r_ok_idx <= 2'd0;

      if (o_hit_err)                   r_err_idx <= 3'd0;
      else if (i_rx_data == w_err_exp) r_err_idx <= r_err_idx + 3'd1;
      else if (i_rx_data == CH_E)      r_err_idx <= 3'd1;
      else                             r_err_idx <= 3'd0;
    end
  end

endmodule

// File: rtl/esp_at_initiator.sv
// AT-command initiator: streams a fixed command into the UART transmitter,
// then waits for "OK\r\n", "ERROR" or a timeout and reports the outcome.
module esp_at_initiator
  import esp_at_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [1:0] i_cmd_sel,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ok,
  output logic       o_err,
  output logic       o_timeout,
  output logic [1:0] o_state
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_sel;
  logic [3:0]       r_idx;
  logic [TMR_W-1:0] r_tmr;
  logic             r_ok, r_err, r_timeout;
  logic             w_accept, w_active, w_xfer, w_last, w_tmo;
  logic             w_hit_ok, w_hit_err, w_hit;

  assign w_accept = (r_state == ST_IDLE) && i_start;
  assign w_active = (r_state == ST_SEND) || (r_state == ST_WAIT_RESP);
  assign w_xfer   = (r_state == ST_SEND) && i_tx_ready;
  assign w_last   = (r_idx == cmd_len(r_sel) - 4'd1);
  assign w_tmo    = (r_state == ST_WAIT_RESP) && (r_tmr == TMR_W'(TIMEOUT_CYCLES - 1));
  assign w_hit    = w_hit_ok || w_hit_err;

  // Handshake: a byte moves on a rising edge where o_tx_valid and i_tx_ready
  // are both high; o_tx_data holds while o_tx_valid is high and unaccepted.
  esp_at_resp_matcher u_matcher (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (w_accept),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid && w_active),
    .o_hit_ok   (w_hit_ok),
    .o_hit_err  (w_hit_err)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    o_busy     = (r_state != ST_IDLE);
    o_done     = 1'b0;
    case (r_state)
      ST_IDLE: if (i_start) w_next = ST_SEND;
      ST_SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = cmd_byte(r_sel, r_idx);
        if (w_hit)                w_next = ST_FINISH;
        else if (w_xfer && w_last) w_next = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: if (w_hit || w_tmo) w_next = ST_FINISH;
      ST_FINISH: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Response window counts only while waiting; it restarts on every entry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sel     <= 2'd0;
      r_idx     <= 4'd0;
      r_tmr     <= '0;
      r_ok      <= 1'b0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sel     <= i_cmd_sel;
        r_idx     <= 4'd0;
        r_ok      <= 1'b0;
        r_err     <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (w_xfer && !w_last) r_idx <= r_idx + 4'd1;
      if (r_state == ST_WAIT_RESP) r_tmr <= r_tmr + 1'b1;
      else                         r_tmr <= '0;
      if (w_hit_ok)       r_ok      <= 1'b1;
      else if (w_hit_err) r_err     <= 1'b1;
      else if (w_tmo)     r_timeout <= 1'b1;
    end
  end

  assign o_ok      = r_ok;
  assign o_err     = r_err;
  assign o_timeout = r_timeout;
  assign o_state   = r_state;

endmodule

// File: tb/tb_esp_at_initiator.sv
// Bench for esp_at_initiator: directed scenarios plus randomized commands and
// replies, scored against a substring-search model of the reply stream.
module tb_esp_at_initiator;

  localparam int TMO = 1000;

  logic       i_clk      = 1'b0;
  logic       i_rst      = 1'b1;
  logic       i_start    = 1'b0;
  logic [1:0] i_cmd_sel  = 2'd0;
  logic       i_tx_ready = 1'b0;
  logic [7:0] i_rx_data  = 8'h00;
  logic       i_rx_valid = 1'b0;
  logic [7:0] o_tx_data;
  logic       o_tx_valid, o_busy, o_done, o_ok, o_err, o_timeout;
  logic [1:0] o_state;

  esp_at_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_cmd_sel  (i_cmd_sel),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_ok       (o_ok),
    .o_err      (o_err),
    .o_timeout  (o_timeout),
    .o_state    (o_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] rx_q[$];
  int   ready_mode    = 0;
  int   done_cnt      = 0;
  int   done_cyc      = 0;
  int   last_xfer_cyc = 0;
  logic prev_stall    = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Ready pattern changes just after each rising edge.
  always @(posedge i_clk) begin
    #1;
    case (ready_mode)
      0:       i_tx_ready = 1'b1;
      1:       i_tx_ready = (cyc % 3 == 0);
      2:       i_tx_ready = ($urandom_range(0, 1) == 1);
      default: i_tx_ready = 1'b0;
    endcase
  end

  // Monitor: sampled mid-cycle; valid&ready here means a transfer at the next edge.
  always @(negedge i_clk) begin
    if (prev_stall && o_tx_valid) check("tx_hold", o_tx_data, prev_data);
    prev_stall = o_tx_valid && !i_tx_ready;
    prev_data  = o_tx_data;
    if (o_tx_valid && i_tx_ready) begin
      got_q.push_back(o_tx_data);
      last_xfer_cyc = cyc;
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- reference model ----------------
  function automatic string cmd_str(input int sel);
    case (sel)
      0:       return "AT\r\n";
      1:       return "AT+RST\r\n";
      2:       return "AT+CWMODE=1\r\n";
      default: return "AT+CIPMUX=1\r\n";
    endcase
  endfunction

  function automatic bit ends_with(input int i, input string p);
    if (i < p.len() - 1) return 1'b0;
    for (int j = 0; j < p.len(); j++)
      if (rx_q[i - p.len() + 1 + j] != p[j]) return 1'b0;
    return 1'b1;
  endfunction

  // 1 = OK, 2 = ERROR, 0 = no terminator anywhere in the reply.
  function automatic int model();
    for (int i = 0; i < rx_q.size(); i++) begin
      if (ends_with(i, "OK\r\n")) return 1;
      if (ends_with(i, "ERROR")) return 2;
    end
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic load_exp(input int sel);
    string s;
    s = cmd_str(sel);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
  endtask

  task automatic add_noise(input int n);
    string alph;
    alph = "OKER\r\nAT";
    for (int i = 0; i < n; i++) rx_q.push_back(alph[$urandom_range(0, alph.len() - 1)]);
  endtask

  task automatic issue(input int sel);
    tick(1);
    i_cmd_sel = 2'(sel);
    i_start   = 1'b1;
    tick(1);
    i_start   = 1'b0;
  endtask

  task automatic wait_sent(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 500) begin
      tick(1);
      t++;
    end
  endtask

  task automatic send_rx(input int gap);
    for (int i = 0; i < rx_q.size(); i++) begin
      i_rx_data  = rx_q[i];
      i_rx_valid = 1'b1;
      tick(1);
      i_rx_valid = 1'b0;
      tick($urandom_range(0, gap));
    end
  endtask

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < TMO + 200) begin
      tick(1);
      t++;
    end
    check("done_seen", done_cnt != d0, 1);
  endtask

  task automatic finish_checks(input int d0, input int code);
    tick(3);
    check("done_pulses", done_cnt - d0, 1);
    check("ok_flag", o_ok, code == 1);
    check("err_flag", o_err, code == 2);
    check("timeout_flag", o_timeout, code == 0);
    check("busy_idle", o_busy, 0);
    check("done_low", o_done, 0);
    check("tx_valid_idle", o_tx_valid, 0);
    if (code == 0) check("tmo_latency", done_cyc - last_xfer_cyc - 1, TMO);
    check("tx_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check("tx_byte", got_q[i], exp_q[i]);
  endtask

  task automatic run_txn(input int sel, input int rmode, input bit poke, input int gap);
    int d0, code;
    load_exp(sel);
    got_q.delete();
    ready_mode = rmode;
    d0 = done_cnt;
    code = model();
    issue(sel);
    check("busy_on_start", o_busy, 1);
    wait_sent(exp_q.size());
    if (poke) begin
      i_cmd_sel = 2'(sel ^ 1);
      i_start   = 1'b1;
      tick(1);
      i_start   = 1'b0;
    end
    send_rx(gap);
    wait_done(d0);
    finish_checks(d0, code);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d0, w, sel, kind, rmode;

    tick(3);
    check("rst_tx_valid", o_tx_valid, 0);
    check("rst_tx_data", o_tx_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_ok", o_ok, 0);
    check("rst_err", o_err, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_state", o_state, 0);
    @(negedge i_clk) i_rst = 1'b0;
    tick(2);
    check("idle_busy", o_busy, 0);

    // Command 0 with its echo ahead of OK.
    rx_q.delete(); push_str("AT\r\n\r\nOK\r\n");
    run_txn(0, 0, 1'b0, 1);

    // Command 2 under 1-of-3 backpressure, ERROR reply.
    rx_q.delete(); push_str("ERROR\r\n");
    run_txn(2, 1, 1'b0, 2);

    // Silent responder: timeout.
    rx_q.delete();
    run_txn(1, 0, 1'b1, 0);

    // Overlap restart and a broken ERROR followed by OK.
    rx_q.delete(); push_str("OOK\r\n");
    run_txn(0, 2, 1'b0, 1);
    rx_q.delete(); push_str("EROK\r\n");
    run_txn(3, 0, 1'b0, 1);

    // Reset while command 3 is presenting byte 5.
    load_exp(3); got_q.delete(); ready_mode = 0;
    issue(3);
    wait_sent(5);
    check("pre_rst_byte5", o_tx_data, exp_q[5]);
    i_rst = 1'b1;
    #1;
    check("mid_rst_tx_valid", o_tx_valid, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_tx_data", o_tx_data, 0);
    @(negedge i_clk) i_rst = 1'b0;
    tick(2);
    rx_q.delete(); push_str("OK\r\n");
    run_txn(3, 0, 1'b0, 0);

    // Final OK byte lands on the last cycle of the response window.
    load_exp(0); got_q.delete(); ready_mode = 0; d0 = done_cnt;
    issue(0);
    wait_sent(4);
    w = last_xfer_cyc + 1;
    while (cyc < w + TMO - 4) tick(1);
    rx_q.delete(); push_str("OK\r\n");
    for (int i = 0; i < 4; i++) begin
      i_rx_data  = rx_q[i];
      i_rx_valid = 1'b1;
      tick(1);
    end
    i_rx_valid = 1'b0;
    wait_done(d0);
    check("edge_done_cycle", done_cyc, w + TMO);
    finish_checks(d0, 1);

    // OK arrives while the command is still stalled: command abandoned.
    exp_q.delete(); got_q.delete(); ready_mode = 3; d0 = done_cnt;
    rx_q.delete(); push_str("OK\r\n");
    issue(2);
    send_rx(1);
    wait_done(d0);
    finish_checks(d0, 1);

    // Randomized commands, backpressure and replies.
    for (int n = 0; n < 16; n++) begin
      sel   = $urandom_range(0, 3);
      kind  = $urandom_range(0, 3);
      rmode = $urandom_range(0, 2);
      rx_q.delete();
      add_noise($urandom_range(0, 6));
      case (kind)
        0: push_str("OK\r\n");
        1: push_str("ERROR");
        3: begin push_str("ERRO"); push_str("OK\r\n"); end
        default: ;
      endcase
      add_noise($urandom_range(0, 4));
      run_txn(sel, rmode, $urandom_range(0, 1) == 1, 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/esp_at_initiator.md
Name: esp_at_initiator

Overview:
- Command-side counterpart to the ESP8266 byte link: the FPGA acts as AT-command initiator and the ESP8266 as responder.
- On a start request, streams one of four fixed AT command strings into the UART transmitter byte interface.
- Scans bytes from the UART receiver for "OK\r\n" or "ERROR", with a timeout.
- Reports a one-cycle completion pulse plus sticky status flags to the controlling logic.

Parameters:
- TIMEOUT_CYCLES, 100000000, response window in clk cycles (2 s at 50 MHz); counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to issue a command; sampled only in IDLE.
- cmd_sel  input  2  0="AT\r\n", 1="AT+RST\r\n", 2="AT+CWMODE=1\r\n", 3="AT+CIPMUX=1\r\n"; latched when start is accepted.
- tx_data  output  8  command byte to the transmitter.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  transmitter can accept a byte.
- rx_data  input  8  byte from the receiver.
- rx_valid  input  1  single-cycle pulse; rx_data valid.
- busy  output  1  high outside IDLE.
- done  output  1  one-cycle pulse on completion.
- ok  output  1  sticky: last command got "OK\r\n".
- err  output  1  sticky: last command got "ERROR".
- timeout  output  1  sticky: last command got no terminator in the window.

Behaviour:
- Interface decision (already decided): one clock; reset is asynchronous and active-high.
- Reset values: tx_data=0, tx_valid=0, busy=0, done=0, ok=0, err=0, timeout=0, state=IDLE, all counters and matchers at 0.
- States: IDLE, SEND, WAIT_RESP, FINISH.
- IDLE -> SEND: on start=1. Actions:
  - latch cmd_sel;
  - clear ok/err/timeout;
  - clear byte index and both matchers.
  - tx_valid rises in the cycle after acceptance, with byte 0.
- SEND, handshake:
  - A transfer occurs on a rising edge with tx_valid=1 and tx_ready=1.
  - tx_data is held stable while tx_valid=1 and tx_ready=0 (backpressure, unbounded).
  - After each transfer, the next byte is presented the following cycle, so tx_valid stays high back-to-back.
- SEND -> WAIT_RESP: on transfer of the last byte (lengths 4/8/13/13). tx_valid=0 from the next cycle.
- Matcher:
  - Active in SEND and WAIT_RESP, so the command echo is tolerated.
  - Two independent index counters: OK_IDX 0..3 over "OK\r\n" and ERR_IDX 0..4 over "ERROR".
  - On each rx_valid:
    - if the byte equals the expected char, the index advances;
    - else, if the byte equals the first char of that pattern, the index becomes 1;
    - else the index becomes 0.
  - Bytes with rx_valid=0 are ignored.
  - In IDLE/FINISH, rx bytes are dropped.
- Completion:
  - OK_IDX completing the pattern sets ok.
  - ERR_IDX completing the pattern sets err.
  - Either one -> FINISH, including if completion happens while still in SEND; any remaining command bytes are abandoned and tx_valid drops next cycle.
- Timeout:
  - The counter starts at 0 on entry to WAIT_RESP and increments each cycle; it is not restarted by rx bytes.
  - Reaching TIMEOUT_CYCLES-1 sets timeout -> FINISH.
- Priority in the same cycle: ok > err > timeout.
- FINISH: done=1 for exactly one cycle, then IDLE. busy=0 from IDLE. Sticky flags hold until the next accepted start.
- start while busy: ignored, not queued.
- rst mid-operation: immediate return to reset values; a byte already accepted by the transmitter still completes on the line.

Decomposition:
- Package esp_at_pkg:
  - state enum;
  - command ROM contents and per-command lengths;
  - character constants (0x4F 'O', 0x4B 'K', 0x0D, 0x0A, "ERROR" bytes).
- Sub-module esp_at_resp_matcher: both pattern counters, with inputs clear, rx_data, rx_valid and outputs hit_ok, hit_err.

Test Plan:
- cmd_sel=0, start, tx_ready=1 -> tx bytes 0x41,0x54,0x0D,0x0A on 4 consecutive transfers; inject "AT\r\n\r\nOK\r\n" -> done pulse, ok=1, err=0, busy=0.
- cmd_sel=2, tx_ready toggled 1-of-3 cycles -> all 13 bytes exact, tx_data stable during stalls; reply "ERROR\r\n" -> err=1 on the 'R' completing the pattern.
- TIMEOUT_CYCLES=1000, cmd_sel=1, no rx -> timeout=1 and done exactly 1000 cycles after entering WAIT_RESP.
- Reply "OOK\r\n" -> ok=1 (overlap restart). Reply "EROK\r\n" -> ok=1, err=0.
- rst asserted during SEND byte 5 of cmd 3 -> tx_valid=0 and busy=0 immediately; a new start afterward sends from byte 0.
- "OK\r\n" final byte and the timeout expiry in the same cycle -> ok=1, timeout=0. A start pulse while busy -> no effect.
